hamming_serial_rx: RTL and testbench

Serial receive-side companion to the team's Hamming(7,4) encoder. It deserializes a framed, LSB-first bitstream of 7-bit Hamming codewords, computes the syndrome, corrects any single-bit error, and presents the 4-bit data nibble on a valid/ready output port. It sits between a serial link front-end and downstream data consumers, and it keeps saturating and sticky link-quality status.

---
 rtl/hamming_serial_rx_if.sv | 22 ++
 rtl/hamming_serial_rx.sv | 159 +++++++++++++++
 tb/tb_hamming_serial_rx.sv | 380 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hamming_serial_rx_if.sv
// Serial-in / nibble-out bus of the Hamming(7,4) receiver.
// The master drives serial bits and out_ready. The slave (the receiver) returns decoded words.
interface hamming_serial_rx_if;
    logic       rx_valid;
    logic       rx_bit;
    logic       rx_sof;
    logic [3:0] out_data;
    logic [2:0] out_syndrome;
    logic       out_corrected;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output rx_valid, rx_bit, rx_sof, out_ready,
        input  out_data, out_syndrome, out_corrected, out_valid
    );

    modport slave (
        input  rx_valid, rx_bit, rx_sof, out_ready,
        output out_data, out_syndrome, out_corrected, out_valid
    );
endinterface

// File: rtl/hamming_serial_rx.sv
// Hamming(7,4) serial receiver: deserializes LSB-first codewords, corrects single-bit errors and delivers the nibble.
// out_valid rises one cycle after the 7th bit. There is no serial backpressure: a word that finds the slot full is dropped and overrun is set.
module hamming_serial_rx #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    hamming_serial_rx_if.slave   io,
    input  logic                 clr_status,
    output logic [CNT_WIDTH-1:0] corr_count,
    output logic                 overrun,
    output logic                 frame_abort
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_DECODE = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic [6:0]           sh_q, sh_d;
    logic [3:0]           out_data_q, out_data_d;
    logic [2:0]           out_syndrome_q, out_syndrome_d;
    logic                 out_corrected_q, out_corrected_d;
    logic                 out_valid_q, out_valid_d;
    logic [CNT_WIDTH-1:0] corr_count_q, corr_count_d;
    logic                 overrun_q, overrun_d;
    logic                 frame_abort_q, frame_abort_d;

    logic [2:0] syn;
    logic [6:0] flip_mask;
    logic [6:0] fixed;
    logic       cnt_inc;
    logic       ovr_set;
    logic       abort_set;
    logic       start_bit;

    // Syndrome value is the 1-based position of the erroneous bit.
    always_comb begin
        syn[0] = sh_q[0] ^ sh_q[2] ^ sh_q[4] ^ sh_q[6];
        syn[1] = sh_q[1] ^ sh_q[2] ^ sh_q[5] ^ sh_q[6];
        syn[2] = sh_q[3] ^ sh_q[4] ^ sh_q[5] ^ sh_q[6];
        flip_mask = 7'd0;
        if (syn != 3'd0) begin
            flip_mask[syn - 3'd1] = 1'b1;
        end
        fixed = sh_q ^ flip_mask;
    end

    assign start_bit = io.rx_valid && io.rx_sof;

    always_comb begin
        state_d         = state_q;
        bit_cnt_d       = bit_cnt_q;
        sh_d            = sh_q;
        out_data_d      = out_data_q;
        out_syndrome_d  = out_syndrome_q;
        out_corrected_d = out_corrected_q;
        out_valid_d     = out_valid_q && !io.out_ready;
        cnt_inc         = 1'b0;
        ovr_set         = 1'b0;
        abort_set       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_bit) begin
                    sh_d      = {6'd0, io.rx_bit};
                    bit_cnt_d = 3'd1;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (start_bit) begin
                    abort_set = 1'b1;
                    sh_d      = {6'd0, io.rx_bit};
                    bit_cnt_d = 3'd1;
                end else if (io.rx_valid) begin
                    sh_d[bit_cnt_q] = io.rx_bit;
                    if (bit_cnt_q == 3'd6) begin
                        bit_cnt_d = 3'd0;
                        state_d   = ST_DECODE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            ST_DECODE: begin
                if (!out_valid_q || io.out_ready) begin
                    out_data_d      = {fixed[6], fixed[5], fixed[4], fixed[2]};
                    out_syndrome_d  = syn;
                    out_corrected_d = (syn != 3'd0);
                    out_valid_d     = 1'b1;
                    cnt_inc         = (syn != 3'd0);
                end else begin
                    ovr_set = 1'b1;
                end
                // A new frame may start in the decode cycle itself.
                if (start_bit) begin
                    sh_d      = {6'd0, io.rx_bit};
                    bit_cnt_d = 3'd1;
                    state_d   = ST_SHIFT;
                end else begin
                    bit_cnt_d = 3'd0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                bit_cnt_d = 3'd0;
                state_d   = ST_IDLE;
            end
        endcase

        corr_count_d  = corr_count_q;
        overrun_d     = overrun_q || ovr_set;
        frame_abort_d = frame_abort_q || abort_set;
        if (clr_status) begin
            corr_count_d  = '0;
            overrun_d     = 1'b0;
            frame_abort_d = 1'b0;
        end else if (cnt_inc && (corr_count_q != {CNT_WIDTH{1'b1}})) begin
            corr_count_d = corr_count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            bit_cnt_q       <= 3'd0;
            sh_q            <= 7'd0;
            out_data_q      <= 4'd0;
            out_syndrome_q  <= 3'd0;
            out_corrected_q <= 1'b0;
            out_valid_q     <= 1'b0;
            corr_count_q    <= '0;
            overrun_q       <= 1'b0;
            frame_abort_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            bit_cnt_q       <= bit_cnt_d;
            sh_q            <= sh_d;
            out_data_q      <= out_data_d;
            out_syndrome_q  <= out_syndrome_d;
            out_corrected_q <= out_corrected_d;
            out_valid_q     <= out_valid_d;
            corr_count_q    <= corr_count_d;
            overrun_q       <= overrun_d;
            frame_abort_q   <= frame_abort_d;
        end
    end

    assign io.out_data      = out_data_q;
    assign io.out_syndrome  = out_syndrome_q;
    assign io.out_corrected = out_corrected_q;
    assign io.out_valid     = out_valid_q;
    assign corr_count       = corr_count_q;
    assign overrun          = overrun_q;
    assign frame_abort      = frame_abort_q;

endmodule

// File: tb/tb_hamming_serial_rx.sv
// Randomized bench for hamming_serial_rx. It checks the receiver against a reference built from
// the Hamming(7,4) parity equations and the position-XOR syndrome property.
module tb_hamming_serial_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr_status;
    logic [7:0] corr_count;
    logic       overrun;
    logic       frame_abort;

    always #5 clk = ~clk;

    hamming_serial_rx_if bus ();

    hamming_serial_rx #(.CNT_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .io         (bus),
        .clr_status (clr_status),
        .corr_count (corr_count),
        .overrun    (overrun),
        .frame_abort(frame_abort)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;

    function automatic logic [6:0] encode(input logic [3:0] d);
        logic p1, p2, p4;
        p1 = d[0] ^ d[1] ^ d[3];
        p2 = d[0] ^ d[2] ^ d[3];
        p4 = d[1] ^ d[2] ^ d[3];
        return {d[3], d[2], d[1], p4, d[0], p2, p1};
    endfunction

    // XOR of the 1-based positions of all set bits: zero for any valid codeword.
    function automatic logic [2:0] syn_of(input logic [6:0] w);
        logic [2:0] s;
        s = 3'd0;
        for (int i = 0; i < 7; i++) begin
            if (w[i]) s = s ^ 3'(i + 1);
        end
        return s;
    endfunction

    function automatic void inc_sat();
        if (exp_cnt < 255) exp_cnt++;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic b, input logic s);
        bus.rx_valid = v;
        bus.rx_bit   = b;
        bus.rx_sof   = s;
        step();
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_frame(input logic [6:0] w, input int max_gap);
        for (int i = 0; i < 7; i++) begin
            if (i > 0 && max_gap > 0) begin
                repeat ($urandom_range(max_gap, 0))
                    drive(1'b0, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
            end
            drive(1'b1, w[i], i == 0);
        end
    endtask

    task automatic clear_status();
        clr_status = 1'b1;
        idle(1);
        clr_status = 1'b0;
        exp_cnt = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        n_checks++;
        if ({bus.out_data, bus.out_syndrome, bus.out_corrected, bus.out_valid,
             corr_count, overrun, frame_abort} !== 20'd0) begin
            n_fail++;
            $display("FAIL reset_state: got data=%h syn=%0d corr=%b vld=%b cnt=%0d ovr=%b abt=%b, expected all zero",
                     bus.out_data, bus.out_syndrome, bus.out_corrected, bus.out_valid,
                     corr_count, overrun, frame_abort);
        end
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_clean();
        bus.out_ready = 1'b1;
        send_frame(7'h55, 0);
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL clean_early_valid: got out_valid=%b expected 0 before decode edge", bus.out_valid);
        end
        idle(1);
        n_checks++;
        if ({bus.out_valid, bus.out_data, bus.out_syndrome, bus.out_corrected} !== {1'b1, 4'b1011, 3'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL clean_word: got vld=%b data=%b syn=%0d corr=%b expected vld=1 data=1011 syn=0 corr=0",
                     bus.out_valid, bus.out_data, bus.out_syndrome, bus.out_corrected);
        end
        n_checks++;
        if (corr_count !== 8'(exp_cnt)) begin
            n_fail++;
            $display("FAIL clean_count: got %0d expected %0d", corr_count, exp_cnt);
        end
        idle(1);
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL clean_consumed: got out_valid=%b expected 0", bus.out_valid);
        end
    endtask

    task automatic test_single_error();
        logic [6:0] w;
        bus.out_ready = 1'b1;
        send_frame(7'h45, 0);
        idle(1);
        inc_sat();
        n_checks++;
        if ({bus.out_valid, bus.out_data, bus.out_syndrome, bus.out_corrected} !== {1'b1, 4'b1011, syn_of(7'h45), 1'b1}) begin
            n_fail++;
            $display("FAIL err_0x45: got vld=%b data=%b syn=%0d corr=%b expected vld=1 data=1011 syn=5 corr=1",
                     bus.out_valid, bus.out_data, bus.out_syndrome, bus.out_corrected);
        end
        n_checks++;
        if (corr_count !== 8'(exp_cnt)) begin
            n_fail++;
            $display("FAIL err_0x45_count: got %0d expected %0d", corr_count, exp_cnt);
        end
        idle(1);
        for (int p = 1; p <= 7; p++) begin
            w = encode(4'b0001) ^ 7'(1 << (p - 1));
            send_frame(w, 0);
            idle(1);
            inc_sat();
            n_checks++;
            if ({bus.out_valid, bus.out_data, bus.out_syndrome, bus.out_corrected} !== {1'b1, 4'b0001, 3'(p), 1'b1}) begin
                n_fail++;
                $display("FAIL sweep_pos%0d: got vld=%b data=%b syn=%0d corr=%b expected vld=1 data=0001 syn=%0d corr=1",
                         p, bus.out_valid, bus.out_data, bus.out_syndrome, bus.out_corrected, p);
            end
            idle(1);
        end
        n_checks++;
        if (corr_count !== 8'(exp_cnt)) begin
            n_fail++;
            $display("FAIL sweep_count: got %0d expected %0d", corr_count, exp_cnt);
        end
    endtask

    task automatic test_overrun();
        bus.out_ready = 1'b0;
        send_frame(7'h55, 0);
        idle(1);
        send_frame(7'h00, 0);
        idle(1);
        send_frame(7'h01, 0);
        idle(1);
        n_checks++;
        if ({bus.out_valid, bus.out_data, overrun} !== {1'b1, 4'b1011, 1'b1}) begin
            n_fail++;
            $display("FAIL overrun_hold: got vld=%b data=%b ovr=%b expected vld=1 data=1011 ovr=1",
                     bus.out_valid, bus.out_data, overrun);
        end
        n_checks++;
        if (corr_count !== 8'(exp_cnt)) begin
            n_fail++;
            $display("FAIL overrun_count: got %0d expected %0d", corr_count, exp_cnt);
        end
        bus.out_ready = 1'b1;
        idle(1);
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_drain: got out_valid=%b expected 0 after one handshake", bus.out_valid);
        end
        idle(3);
        n_checks++;
        if ({bus.out_valid, overrun} !== 2'b01) begin
            n_fail++;
            $display("FAIL overrun_after: got vld=%b ovr=%b expected vld=0 ovr=1", bus.out_valid, overrun);
        end
        clear_status();
        n_checks++;
        if ({corr_count, overrun, frame_abort} !== 10'd0) begin
            n_fail++;
            $display("FAIL clear_status: got cnt=%0d ovr=%b abt=%b expected all zero", corr_count, overrun, frame_abort);
        end
    endtask

    task automatic test_abort();
        int words;
        bus.out_ready = 1'b1;
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        send_frame(7'h07, 0);
        n_checks++;
        if ({frame_abort, bus.out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL abort_flag: got abt=%b vld=%b expected abt=1 vld=0", frame_abort, bus.out_valid);
        end
        words = 0;
        for (int c = 0; c < 6; c++) begin
            idle(1);
            if (bus.out_valid) begin
                words++;
                n_checks++;
                if (bus.out_data !== 4'b0001) begin
                    n_fail++;
                    $display("FAIL abort_data: got %b expected 0001", bus.out_data);
                end
            end
        end
        n_checks++;
        if (words != 1) begin
            n_fail++;
            $display("FAIL abort_words: got %0d words expected 1", words);
        end
        clear_status();
    endtask

    task automatic test_back_to_back();
        localparam int N = 24;
        logic [6:0] exp_q[$];
        int got;
        bus.out_ready = 1'b1;
        got = 0;
        repeat (3) drive(1'b1, 1'b1, 1'b0);
        fork
            begin
                logic [3:0] d;
                logic [6:0] w;
                int pos;
                for (int k = 0; k < N; k++) begin
                    d   = 4'($urandom_range(15, 0));
                    pos = $urandom_range(1, 0) ? int'($urandom_range(7, 1)) : 0;
                    w   = encode(d);
                    if (pos != 0) begin
                        w = w ^ 7'(1 << (pos - 1));
                        inc_sat();
                    end
                    exp_q.push_back({d, syn_of(w)});
                    send_frame(w, 3);
                    if ($urandom_range(1, 0) == 1) begin
                        repeat ($urandom_range(3, 1)) drive(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'b0);
                    end
                end
                idle(4);
            end
            begin
                logic [6:0] e;
                for (int c = 0; c < 4000 && got < N; c++) begin
                    @(posedge clk);
                    #1;
                    if (bus.out_valid) begin
                        n_checks++;
                        if (exp_q.size() == 0) begin
                            n_fail++;
                            $display("FAIL b2b_spurious: got data=%b syn=%0d with no word expected", bus.out_data, bus.out_syndrome);
                        end else begin
                            e = exp_q.pop_front();
                            if ({bus.out_data, bus.out_syndrome, bus.out_corrected} !== {e, e[2:0] != 3'd0}) begin
                                n_fail++;
                                $display("FAIL b2b_word%0d: got data=%b syn=%0d corr=%b expected data=%b syn=%0d",
                                         got, bus.out_data, bus.out_syndrome, bus.out_corrected, e[6:3], e[2:0]);
                            end
                        end
                        got++;
                    end
                end
            end
        join
        n_checks++;
        if (got != N || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_total: got %0d words (%0d left) expected %0d", got, exp_q.size(), N);
        end
        n_checks++;
        if (corr_count !== 8'(exp_cnt)) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d expected %0d", corr_count, exp_cnt);
        end
    endtask

    task automatic test_saturation();
        logic [6:0] w;
        bus.out_ready = 1'b1;
        clear_status();
        for (int k = 0; k < 300; k++) begin
            w = encode(4'($urandom_range(15, 0))) ^ 7'(1 << $urandom_range(6, 0));
            send_frame(w, 0);
            inc_sat();
        end
        idle(2);
        n_checks++;
        if (corr_count !== 8'(exp_cnt)) begin
            n_fail++;
            $display("FAIL sat_count: got %0d expected %0d", corr_count, exp_cnt);
        end
        send_frame(encode(4'b1100) ^ 7'h08, 0);
        clear_status();
        n_checks++;
        if ({corr_count, bus.out_valid, bus.out_data, bus.out_corrected} !== {8'd0, 1'b1, 4'b1100, 1'b1}) begin
            n_fail++;
            $display("FAIL clr_vs_inc: got cnt=%0d vld=%b data=%b corr=%b expected cnt=0 vld=1 data=1100 corr=1",
                     corr_count, bus.out_valid, bus.out_data, bus.out_corrected);
        end
        idle(1);
    endtask

    task automatic test_reset_midframe();
        int spurious;
        bus.out_ready = 1'b0;
        send_frame(7'h45, 0);
        idle(1);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'(7'h55 >> i), i == 0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        n_checks++;
        if ({bus.out_data, bus.out_syndrome, bus.out_corrected, bus.out_valid,
             corr_count, overrun, frame_abort} !== 20'd0) begin
            n_fail++;
            $display("FAIL rst_mid: got data=%h syn=%0d corr=%b vld=%b cnt=%0d ovr=%b abt=%b expected all zero",
                     bus.out_data, bus.out_syndrome, bus.out_corrected, bus.out_valid,
                     corr_count, overrun, frame_abort);
        end
        bus.out_ready = 1'b1;
        spurious = 0;
        for (int i = 4; i < 7; i++) begin
            drive(1'b1, 1'(7'h55 >> i), 1'b0);
            if (bus.out_valid) spurious++;
        end
        repeat (8) begin
            idle(1);
            if (bus.out_valid) spurious++;
        end
        n_checks++;
        if (spurious != 0) begin
            n_fail++;
            $display("FAIL rst_spurious: got %0d output cycles expected 0", spurious);
        end
    endtask

    initial begin
        rst           = 1'b1;
        clr_status    = 1'b0;
        bus.rx_valid  = 1'b0;
        bus.rx_bit    = 1'b0;
        bus.rx_sof    = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_clean();
        test_single_error();
        test_overrun();
        test_abort();
        test_back_to_back();
        test_saturation();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
